// File: rtl/mul_lane.sv
// Multi-lane FP / sign-magnitude integer multiplier front end: decode stage, then product stage, valid/ready handshake.
// Define MUL_LANE_SAT_EN to remove BIAS from the exponent sum and saturate it, with overflow/underflow flags.
module mul_lane #(
  parameter int EXP_W = 4,
  parameter int MAN_W = 11,
  parameter int INT_W = 8,
  parameter int LANES = 2,
  parameter int BIAS  = 7,
  localparam int OP_W = 1 + EXP_W + MAN_W,
  localparam int PW   = 2 * (MAN_W + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_fp,
  input  logic [LANES*OP_W-1:0]        in_op1,
  input  logic [LANES*OP_W-1:0]        in_op2,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_fp,
  output logic [LANES*PW-1:0]          out_man,
  output logic [LANES*(EXP_W+1)-1:0]   out_exp,
  output logic [LANES-1:0]             out_sgn,
  output logic [LANES-1:0]             out_zero,
  output logic [LANES-1:0]             out_ovf,
  output logic [LANES-1:0]             out_unf
);

  localparam int SIG_W = MAN_W + 1;
  localparam int EW    = EXP_W + 1;

  function automatic logic dec_sgn(input logic [OP_W-1:0] op, input logic fp);
    return fp ? op[OP_W-1] : op[INT_W-1];
  endfunction

  function automatic logic [EXP_W-1:0] dec_exp(input logic [OP_W-1:0] op, input logic fp);
    return fp ? op[OP_W-2:MAN_W] : '0;
  endfunction

  // Integer magnitudes are left-aligned so both modes share one significand multiplier.
  function automatic logic [SIG_W-1:0] dec_sig(input logic [OP_W-1:0] op, input logic fp);
    logic [SIG_W-1:0] s;
    s = '0;
    if (fp) s = {|op[OP_W-2:0], op[MAN_W-1:0]};
    else    s[SIG_W-1 -: INT_W-1] = op[INT_W-2:0];
    return s;
  endfunction

  logic                         s1_valid, s1_fp;
  logic [LANES-1:0]             s1_sgn, s1_zero;
  logic [LANES-1:0][EW-1:0]     s1_exp;
  logic [LANES-1:0][SIG_W-1:0]  s1_sig1, s1_sig2;

  logic [LANES-1:0]             d_sgn, d_zero;
  logic [LANES-1:0][EW-1:0]     d_exp;
  logic [LANES-1:0][SIG_W-1:0]  d_sig1, d_sig2;

  logic [LANES*PW-1:0]          n_man;
  logic [LANES*EW-1:0]          n_exp;
  logic [LANES-1:0]             n_ovf, n_unf;

  logic ld1, ld2;

  assign ld2      = !out_valid || out_ready;
  assign ld1      = !s1_valid || ld2;
  assign in_ready = ld1 && !flush;

  always_comb begin
    d_sgn  = '0;
    d_zero = '0;
    d_exp  = '0;
    d_sig1 = '0;
    d_sig2 = '0;
    for (int i = 0; i < LANES; i++) begin
      d_sgn[i]  = dec_sgn(in_op1[i*OP_W +: OP_W], in_fp) ^ dec_sgn(in_op2[i*OP_W +: OP_W], in_fp);
      d_exp[i]  = {1'b0, dec_exp(in_op1[i*OP_W +: OP_W], in_fp)}
                + {1'b0, dec_exp(in_op2[i*OP_W +: OP_W], in_fp)};
      d_sig1[i] = dec_sig(in_op1[i*OP_W +: OP_W], in_fp);
      d_sig2[i] = dec_sig(in_op2[i*OP_W +: OP_W], in_fp);
      d_zero[i] = (d_sig1[i] == '0) || (d_sig2[i] == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_fp    <= 1'b0;
      s1_sgn   <= '0;
      s1_zero  <= '0;
      s1_exp   <= '0;
      s1_sig1  <= '0;
      s1_sig2  <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (ld1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_fp   <= in_fp;
        s1_sgn  <= d_sgn;
        s1_zero <= d_zero;
        s1_exp  <= d_exp;
        s1_sig1 <= d_sig1;
        s1_sig2 <= d_sig2;
      end
    end
  end

`ifdef MUL_LANE_SAT_EN
  localparam logic signed [EXP_W+2:0] BIAS_V = (EXP_W+3)'(BIAS);
  logic signed [EXP_W+2:0] t;
`endif

  always_comb begin
    n_man = '0;
    n_exp = '0;
    n_ovf = '0;
    n_unf = '0;
`ifdef MUL_LANE_SAT_EN
    t = '0;
`endif
    for (int i = 0; i < LANES; i++) begin
      n_man[i*PW +: PW] = {{SIG_W{1'b0}}, s1_sig1[i]} * {{SIG_W{1'b0}}, s1_sig2[i]};
`ifdef MUL_LANE_SAT_EN
      t = $signed({2'b00, s1_exp[i]}) - BIAS_V;
      if (!s1_zero[i]) begin
        if (t[EXP_W+2]) begin
          n_unf[i] = s1_fp;
        end else if (t[EXP_W+1:EXP_W] != 2'b00) begin
          n_exp[i*EW +: EW] = {1'b0, {EXP_W{1'b1}}};
          n_ovf[i]          = s1_fp;
        end else begin
          n_exp[i*EW +: EW] = t[EW-1:0];
        end
      end
`else
      if (!s1_zero[i]) n_exp[i*EW +: EW] = s1_exp[i];
`endif
    end
  end

  // Output data only changes when a real beat moves in, so stalls and bubbles keep it bit-stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_fp    <= 1'b0;
      out_man   <= '0;
      out_exp   <= '0;
      out_sgn   <= '0;
      out_zero  <= '0;
      out_ovf   <= '0;
      out_unf   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (ld2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_fp   <= s1_fp;
        out_man  <= n_man;
        out_exp  <= n_exp;
        out_sgn  <= s1_sgn;
        out_zero <= s1_zero;
        out_ovf  <= n_ovf;
        out_unf  <= n_unf;
      end
    end
  end

endmodule

// File: tb/tb_mul_lane.sv
// Directed-vector bench for mul_lane (two lanes, default widths); expectations follow MUL_LANE_SAT_EN.
module tb_mul_lane;

  localparam int LANES = 2;
  localparam int OP_W  = 16;
  localparam int PW    = 24;
  localparam int EW    = 5;
`ifdef MUL_LANE_SAT_EN
  localparam bit SAT_ON = 1'b1;
`else
  localparam bit SAT_ON = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    flush = 1'b0;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic                    in_fp = 1'b0;
  logic [LANES*OP_W-1:0]   in_op1 = '0;
  logic [LANES*OP_W-1:0]   in_op2 = '0;
  logic                    out_valid;
  logic                    out_ready = 1'b1;
  logic                    out_fp;
  logic [LANES*PW-1:0]     out_man;
  logic [LANES*EW-1:0]     out_exp;
  logic [LANES-1:0]        out_sgn, out_zero, out_ovf, out_unf;

  mul_lane dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_fp(in_fp),
    .in_op1(in_op1), .in_op2(in_op2),
    .out_valid(out_valid), .out_ready(out_ready), .out_fp(out_fp),
    .out_man(out_man), .out_exp(out_exp), .out_sgn(out_sgn),
    .out_zero(out_zero), .out_ovf(out_ovf), .out_unf(out_unf)
  );

  always #5 clk = ~clk;

  // en: raw exponent sum; es/o/u: biased-and-saturated exponent and flags.
  typedef struct packed {
    logic [15:0] a, b;
    logic [23:0] m;
    logic [4:0]  en, es;
    logic        s, z, o, u;
  } lane_t;

  typedef struct packed {
    logic  fp;
    lane_t l0;
    lane_t l1;
  } vec_t;

  vec_t vt[7];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic drive_vec(input int k);
    in_fp  = vt[k].fp;
    in_op1 = {vt[k].l1.a, vt[k].l0.a};
    in_op2 = {vt[k].l1.b, vt[k].l0.b};
  endtask

  task automatic check_vec(input string tag, input int k);
    lane_t l;
    chk($sformatf("%s v%0d fp", tag, k), {31'b0, out_fp}, {31'b0, vt[k].fp});
    for (int i = 0; i < LANES; i++) begin
      l = (i == 0) ? vt[k].l0 : vt[k].l1;
      chk($sformatf("%s v%0d L%0d man", tag, k, i), {8'b0, out_man[i*PW +: PW]}, {8'b0, l.m});
      chk($sformatf("%s v%0d L%0d exp", tag, k, i), {27'b0, out_exp[i*EW +: EW]},
          {27'b0, SAT_ON ? l.es : l.en});
      chk($sformatf("%s v%0d L%0d sgn", tag, k, i), {31'b0, out_sgn[i]}, {31'b0, l.s});
      chk($sformatf("%s v%0d L%0d zero", tag, k, i), {31'b0, out_zero[i]}, {31'b0, l.z});
      chk($sformatf("%s v%0d L%0d ovf", tag, k, i), {31'b0, out_ovf[i]}, {31'b0, SAT_ON & l.o});
      chk($sformatf("%s v%0d L%0d unf", tag, k, i), {31'b0, out_unf[i]}, {31'b0, SAT_ON & l.u});
    end
  endtask

  // Single beat, out_ready high: accepted on edge 1, visible after edge 2.
  task automatic apply_vec(input string tag, input int k);
    @(negedge clk);
    drive_vec(k);
    in_valid = 1'b1;
    #1 chk($sformatf("%s v%0d in_ready", tag, k), {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk($sformatf("%s v%0d early out_valid", tag, k), {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    chk($sformatf("%s v%0d out_valid", tag, k), {31'b0, out_valid}, 32'd1);
    check_vec(tag, k);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int seq[8];
    int tx, rx;
    bit fire_in, fire_out, saw_drop;

    //         fp     lane0: a      b       man         en    es    s     z     o     u
    vt[0] = '{1'b1, '{16'h3800, 16'h3800, 24'h400000, 5'd14, 5'd7,  1'b0, 1'b0, 1'b0, 1'b0},
                    '{16'h8000, 16'h3C00, 24'h000000, 5'd0,  5'd0,  1'b1, 1'b1, 1'b0, 1'b0}};
    vt[1] = '{1'b0, '{16'h0005, 16'h0083, 24'h003C00, 5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0},
                    '{16'h127F, 16'h807F, 24'hFC0400, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0}};
    vt[2] = '{1'b1, '{16'h7800, 16'h7800, 24'h400000, 5'd30, 5'd15, 1'b0, 1'b0, 1'b1, 1'b0},
                    '{16'h0800, 16'h0800, 24'h400000, 5'd2,  5'd0,  1'b0, 1'b0, 1'b0, 1'b1}};
    vt[3] = '{1'b1, '{16'hBC00, 16'h3C00, 24'h900000, 5'd14, 5'd7,  1'b1, 1'b0, 1'b0, 1'b0},
                    '{16'hC400, 16'hC200, 24'h780000, 5'd16, 5'd9,  1'b0, 1'b0, 1'b0, 1'b0}};
    vt[4] = '{1'b0, '{16'h0080, 16'h0005, 24'h000000, 5'd0,  5'd0,  1'b1, 1'b1, 1'b0, 1'b0},
                    '{16'h00FF, 16'h0081, 24'h01FC00, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0}};
    vt[5] = '{1'b1, '{16'h0001, 16'h0400, 24'h600C00, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b1},
                    '{16'h7FFF, 16'h7FFF, 24'hFFE001, 5'd30, 5'd15, 1'b0, 1'b0, 1'b1, 1'b0}};
    vt[6] = '{1'b1, '{16'h3800, 16'h0400, 24'h600000, 5'd7,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0},
                    '{16'h7800, 16'h3800, 24'h400000, 5'd22, 5'd15, 1'b0, 1'b0, 1'b0, 1'b0}};
    seq = '{0, 1, 2, 4, 3, 1, 5, 4};

    // Reset values
    @(negedge clk);
    @(negedge clk);
    chk("rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst out_fp", {31'b0, out_fp}, 32'd0);
    chk("rst out_man", {8'b0, out_man[47:24]} | {8'b0, out_man[23:0]}, 32'd0);
    chk("rst out_exp", {22'b0, out_exp}, 32'd0);
    chk("rst flags", {24'b0, out_sgn, out_zero, out_ovf, out_unf}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-rst in_ready", {31'b0, in_ready}, 32'd1);

    for (int k = 0; k < 7; k++) apply_vec("table", k);

    // Alternating-mode stream with a 3-cycle consumer stall
    tx = 0;
    rx = 0;
    saw_drop = 1'b0;
    for (int cyc = 0; cyc < 40 && rx < 8; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 4 && cyc <= 6);
      if (tx < 8) begin
        drive_vec(seq[tx]);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      chk($sformatf("stream c%0d in_ready", cyc), {31'b0, in_ready},
          {31'b0, !((tx - rx) == 2 && !out_ready)});
      if (!in_ready) saw_drop = 1'b1;
      if (out_valid) begin
        if (rx < 8) check_vec($sformatf("stream c%0d", cyc), seq[rx]);
        else chk("stream extra beat", {31'b0, out_valid}, 32'd0);
      end
      fire_in  = in_valid && in_ready;
      fire_out = out_valid && out_ready;
      @(posedge clk);
      if (fire_in) tx++;
      if (fire_out) rx++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("stream beats received", rx, 32'd8);
    chk("stream in_ready dropped", {31'b0, saw_drop}, 32'd1);

    // Flush with both stages full and out_ready high
    @(negedge clk);
    drive_vec(0);
    in_valid = 1'b1;
    @(negedge clk);
    drive_vec(1);
    @(negedge clk);
    drive_vec(2);
    flush = 1'b1;
    #1;
    chk("flush in_ready", {31'b0, in_ready}, 32'd0);
    chk("flush pre out_valid", {31'b0, out_valid}, 32'd1);
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush out_valid", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    chk("flush drained", {31'b0, out_valid}, 32'd0);
    apply_vec("post-flush", 6);

    // Async reset while stalled with both stages full
    @(negedge clk);
    out_ready = 1'b0;
    drive_vec(2);
    in_valid = 1'b1;
    @(negedge clk);
    drive_vec(3);
    @(negedge clk);
    in_valid = 1'b0;
    chk("stall-rst pre out_valid", {31'b0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("stall-rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("stall-rst out_man", {8'b0, out_man[23:0]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("post-rst out_valid 1", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    chk("post-rst out_valid 2", {31'b0, out_valid}, 32'd0);
    chk("post-rst out_man", {8'b0, out_man[47:24]} | {8'b0, out_man[23:0]}, 32'd0);
    apply_vec("post-rst", 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
